// File: rtl/baud_gen_ovs.sv
// baud_gen_ovs: oversampling baud generator (tick / mid_tick / bit_tick); define BAUD_FRAC_EN for fractional divisor
module baud_gen_ovs #(
    parameter int CNT_W = 16,
    parameter int OVS   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] dvsr,
    input  logic             dvsr_ld,
    input  logic             sync_clr,
`ifdef BAUD_FRAC_EN
    input  logic [3:0]       dvsr_frac,
`endif
    output logic             tick,
    output logic             mid_tick,
    output logic             bit_tick
);
    localparam int OW = $clog2(OVS);
    logic [CNT_W-1:0] cnt, div_q, pend_val;
    logic [OW-1:0]    ovs_cnt;
    logic             pend_q, at_top, hold, wrap;
    assign at_top = cnt == div_q;
    assign wrap   = en & at_top & ~hold & ~sync_clr;
`ifdef BAUD_FRAC_EN
    logic [3:0] acc, frac_q, pend_frac;
    logic [4:0] acc_sum;
    logic       stretch;
    assign acc_sum = {1'b0, acc} + {1'b0, frac_q};
    assign hold    = stretch;
    // a carry out of acc stretches the following period by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            frac_q    <= '0;
            pend_frac <= '0;
            stretch   <= 1'b0;
        end else begin
            if (sync_clr) begin
                acc     <= '0;
                stretch <= 1'b0;
            end else if (wrap) begin
                acc     <= acc_sum[3:0];
                stretch <= acc_sum[4];
            end else if (en && at_top)
                stretch <= 1'b0;
            if (dvsr_ld && !en)
                frac_q <= dvsr_frac;
            else if (wrap)
                frac_q <= dvsr_ld ? dvsr_frac : pend_q ? pend_frac : frac_q;
            else if (dvsr_ld)
                pend_frac <= dvsr_frac;
        end
    end
`else
    assign hold = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            ovs_cnt  <= '0;
            div_q    <= '0;
            pend_q   <= 1'b0;
            pend_val <= '0;
            tick     <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            tick     <= wrap;
            mid_tick <= wrap && ovs_cnt == OW'(OVS/2-1);
            bit_tick <= wrap && ovs_cnt == OW'(OVS-1);
            if (sync_clr) begin
                cnt     <= '0;
                ovs_cnt <= '0;
            end else if (en) begin
                cnt     <= wrap ? '0 : (hold && at_top) ? cnt : cnt + 1'b1;
                ovs_cnt <= wrap ? ovs_cnt + 1'b1 : ovs_cnt;
            end
            // idle loads apply at once; running loads wait for the period boundary
            if (dvsr_ld && !en) begin
                div_q  <= dvsr;
                pend_q <= 1'b0;
                cnt    <= '0;
            end else if (wrap) begin
                div_q  <= dvsr_ld ? dvsr : pend_q ? pend_val : div_q;
                pend_q <= 1'b0;
            end else if (dvsr_ld) begin
                pend_q   <= 1'b1;
                pend_val <= dvsr;
            end
        end
    end
endmodule

// File: tb/tb_baud_gen_ovs.sv
// tb_baud_gen_ovs: random + directed stimulus against a countdown reference model, queue scoreboard
module tb_baud_gen_ovs;
    localparam int CNT_W = 5;
    localparam int OVS   = 16;
    logic clk = 1'b0;
    logic reset = 1'b1, en = 1'b0, dvsr_ld = 1'b0, sync_clr = 1'b0;
    logic [CNT_W-1:0] dvsr = '0;
    logic tick, mid_tick, bit_tick;
`ifdef BAUD_FRAC_EN
    logic [3:0] dvsr_frac = 4'd0;
`endif
    always #5 clk = ~clk;
    baud_gen_ovs #(.CNT_W(CNT_W), .OVS(OVS)) dut (
        .clk(clk), .reset(reset), .en(en), .dvsr(dvsr), .dvsr_ld(dvsr_ld),
        .sync_clr(sync_clr),
`ifdef BAUD_FRAC_EN
        .dvsr_frac(dvsr_frac),
`endif
        .tick(tick), .mid_tick(mid_tick), .bit_tick(bit_tick));
    logic [2:0] exp_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int left = 1, div = 0, pval = 0, ntick = 0;
    bit pend = 1'b0;
    always @(negedge clk) begin : monitor
        logic [2:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({tick, mid_tick, bit_tick} !== e) begin
                errors++;
                $display("FAIL strobes cyc %0d: got tick/mid/bit=%b want %b", cyc, {tick, mid_tick, bit_tick}, e);
            end
        end
    end
    // left = enabled clocks until the period ends; ntick = ticks since phase origin
    task automatic model(input bit r, input bit e, input bit ld, input bit sc, input int d);
        logic [2:0] x;
        x = 3'b000;
        if (r) begin
            left = 1; div = 0; pend = 0; ntick = 0;
        end else if (sc) begin
            left = div + 1; ntick = 0;
        end else if (!e) begin
            if (ld) begin div = d; left = d + 1; pend = 0; end
        end else begin
            left--;
            if (left == 0) begin
                x[2] = 1'b1;
                x[1] = (ntick % OVS) == OVS/2 - 1;
                x[0] = (ntick % OVS) == OVS - 1;
                ntick++;
                div  = ld ? d : pend ? pval : div;
                pend = 0;
                left = div + 1;
            end else if (ld) begin
                pend = 1; pval = d;
            end
        end
        exp_q.push_back(x);
    endtask
    task automatic step(input bit r, input bit e, input bit ld, input bit sc, input int d);
        @(negedge clk);
        reset = r; en = e; dvsr_ld = ld; sync_clr = sc; dvsr = CNT_W'(d);
        @(posedge clk);
        model(r, e, ld, sc, d);
    endtask
    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(0, e, 0, 0, 0);
    endtask
    initial begin
        int d;
        bit r, e, ld, sc;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 3);
        run(24, 1);
        step(0, 0, 1, 0, 0);
        run(40, 1);
        step(0, 0, 1, 0, 9);
        run(13, 1);
        step(0, 1, 1, 0, 4);
        run(30, 1);
        step(0, 1, 1, 0, 9);
        run(85, 1);
        step(0, 1, 0, 1, 0);
        run(180, 1);
        run(5, 0);
        run(7, 1);
        step(0, 1, 1, 0, 20);
        step(1, 1, 0, 0, 0);
        run(10, 1);
        step(0, 0, 1, 0, 31);
        run(70, 1);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom % 400) == 0;
            ld = ($urandom % 30) == 0;
            sc = !ld && ($urandom % 60) == 0;
            e  = ($urandom % 8) != 0;
            case ($urandom % 10)
                0:       d = 31;
                1, 2, 3: d = $urandom_range(0, 12);
                default: d = $urandom_range(0, 4);
            endcase
            step(r, e, ld, sc, d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
